// File: rtl/switch_debounce_filter.sv
// Switch debouncer: two-flop synchroniser, stability counter,
// registered level plus rise/fall pulses and a press toggle.
module switch_debounce_filter #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Toggle
);

  localparam int unsigned CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          switch_q;
  logic          switch_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;
  logic          toggle_q;
  logic          toggle_d;

  // Bring the asynchronous pad into the clock domain.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatches; accept the new level at terminal count.
  always_comb begin
    count_d  = count_q;
    switch_d = switch_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    if (sync2_q == switch_q) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d  = '0;
      switch_d = sync2_q;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
      toggle_d = toggle_q ^ sync2_q;
    end else begin
      count_d = count_q + ONE;
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q  <= '0;
      switch_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      switch_q <= switch_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign o_Switch = switch_q;
  assign o_Rise   = rise_q;
  assign o_Fall   = fall_q;
  assign o_Toggle = toggle_q;

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Bench for switch_debounce_filter with DEBOUNCE_LIMIT=4:
// vector table for press/release/bounce, directed reset sequences.
module tb_switch_debounce_filter;

  logic clk;
  logic rst_n;
  logic sw;
  logic o_sw;
  logic o_rise;
  logic o_fall;
  logic o_tog;

  int checks;
  int failures;

  typedef struct packed {
    logic sw;
    logic e_sw;
    logic e_rise;
    logic e_fall;
    logic e_tog;
  } vec_t;

  localparam int NV = 54;
  vec_t tbl [NV];

  switch_debounce_filter #(
    .DEBOUNCE_LIMIT(4)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Switch(sw),
    .o_Switch(o_sw),
    .o_Rise  (o_rise),
    .o_Fall  (o_fall),
    .o_Toggle(o_tog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic es,
                         input logic er, input logic ef,
                         input logic et);
    chk({tag, " o_Switch"}, o_sw, es);
    chk({tag, " o_Rise"}, o_rise, er);
    chk({tag, " o_Fall"}, o_fall, ef);
    chk({tag, " o_Toggle"}, o_tog, et);
  endtask

  // Drive the switch, take one rising edge, sample 1 ns later.
  task automatic step(input logic s);
    sw = s;
    @(posedge clk);
    #1;
  endtask

  task automatic set(input int lo, input int hi, input logic s,
                     input logic es, input logic er,
                     input logic ef, input logic et);
    for (int i = lo; i <= hi; i++) begin
      tbl[i] = '{sw: s, e_sw: es, e_rise: er,
                 e_fall: ef, e_tog: et};
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // idle
    set(0, 1, 0, 0, 0, 0, 0);
    // clean press, capture at row 2, accept at row 7
    set(2, 6, 1, 0, 0, 0, 0);
    set(7, 7, 1, 1, 1, 0, 1);
    set(8, 9, 1, 1, 0, 0, 1);
    // release, capture at row 10, accept at row 15
    set(10, 14, 0, 1, 0, 0, 1);
    set(15, 15, 0, 0, 0, 1, 1);
    set(16, 17, 0, 0, 0, 0, 1);
    // bounce rejection: 3 high, 2 low, 3 high, low
    set(18, 20, 1, 0, 0, 0, 1);
    set(21, 22, 0, 0, 0, 0, 1);
    set(23, 25, 1, 0, 0, 0, 1);
    set(26, 29, 0, 0, 0, 0, 1);
    // bounce then settle: final capture row 33, accept row 38
    set(30, 31, 1, 0, 0, 0, 1);
    set(32, 32, 0, 0, 0, 0, 1);
    set(33, 37, 1, 0, 0, 0, 1);
    set(38, 38, 1, 1, 1, 0, 0);
    set(39, 40, 1, 1, 0, 0, 0);
    // release then press again to leave toggle at 1
    set(41, 45, 0, 1, 0, 0, 0);
    set(46, 46, 0, 0, 0, 1, 0);
    set(47, 51, 1, 0, 0, 0, 0);
    set(52, 52, 1, 1, 1, 0, 1);
    set(53, 53, 1, 1, 0, 0, 1);

    rst_n = 1'b0;
    sw    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].sw);
      chk_all($sformatf("row%0d", i), tbl[i].e_sw,
              tbl[i].e_rise, tbl[i].e_fall, tbl[i].e_tog);
    end

    // Asynchronous reset mid-cycle with the switch held high.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);

    // Held high through release, then reset after 2 counted cycles.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk_all($sformatf("pre_rst%0d", i), 0, 0, 0, 0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk_all($sformatf("post_rst%0d", i), 0, 0, 0, 0);
    end
    step(1'b1);
    chk_all("post_rst_accept", 1, 1, 0, 1);
    step(1'b1);
    chk_all("post_rst_after", 1, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
